serial_rx_deframer: RTL

- Receive-side counterpart of the b13 serial transmitter.
- Recovers 10-bit frames from the one-wire serial line: start bit (0), 8 data bits MSB first, stop bit (1), idle level 1.
- Oversamples with the system clock at a fixed bit period, checks framing, and presents each byte through a one-entry valid/ready holding register to the downstream controller.

---
 rtl/serial_pkg.sv | 38 +++
 rtl/serial_rx_sync.sv | 34 +++
 rtl/serial_rx_deframer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared serial frame definition for the b13-style transmitter and its receiver.
// Latency: none (types and constants only).
// Backpressure: n/a.
package serial_pkg;

  // Receiver state encodings
  typedef enum logic [1:0] {
    R_IDLE  = 2'b00,
    R_START = 2'b01,
    R_DATA  = 2'b10,
    R_STOP  = 2'b11
  } rx_state_t;

  // Transmitter bit-slot encodings, kept here so both ends agree on the frame
  typedef enum logic [3:0] {
    START_BIT = 4'd0,
    STOP_BIT  = 4'd1,
    BIT0      = 4'd2,
    BIT1      = 4'd3,
    BIT2      = 4'd4,
    BIT3      = 4'd5,
    BIT4      = 4'd6,
    BIT5      = 4'd7,
    BIT6      = 4'd8,
    BIT7      = 4'd9
  } tx_state_t;

  localparam int FRAME_DATA_BITS    = 8;
  localparam int FRAME_BITS         = FRAME_DATA_BITS + 2;
  localparam int DEFAULT_BIT_PERIOD = 106;
  localparam int BIT_CNT_W          = 10;
  localparam int BIT_IDX_W          = 3;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/serial_rx_sync.sv
// Two-flop synchronizer for the serial line plus falling-edge detect.
// Latency: line change visible on rxd_sync two clocks later; fall is combinational from flops.
// Backpressure: none; free-running sampler. Flops reset to the idle level so no false start.
module serial_rx_sync
  import serial_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic rxd,
  output logic rxd_sync,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Resynchronize the asynchronous line and keep one cycle of history for edge detect
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= LINE_IDLE;
      sync_q <= LINE_IDLE;
      prev_q <= LINE_IDLE;
    end else begin
      meta_q <= rxd;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rxd_sync = sync_q;
  assign fall     = prev_q & ~sync_q;

endmodule

// File: rtl/serial_rx_deframer.sv
// Serial receiver: start/8 data (MSB first)/stop deframing into a one-entry holding register.
// Latency: stop sample HALF_PERIOD+9*BIT_PERIOD cycles after the detected start edge, rx_valid one cycle later.
// Backpressure: rx_valid/rx_ready; a good frame arriving while the register is full is dropped with an overrun pulse.
module serial_rx_deframer
  import serial_pkg::*;
#(
  parameter int BIT_PERIOD  = DEFAULT_BIT_PERIOD,  // clocks per bit, legal range 4..1023
  parameter int HALF_PERIOD = BIT_PERIOD / 2       // start edge to start-bit mid-sample
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       rxd,
  input  logic                       rx_en,
  output logic [FRAME_DATA_BITS-1:0] rx_data,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic                       frame_error,
  output logic                       overrun,
  output logic                       busy
);

  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(BIT_PERIOD - 1);
  localparam logic [BIT_CNT_W-1:0] HALF_LAST = BIT_CNT_W'(HALF_PERIOD - 1);
  localparam logic [BIT_IDX_W-1:0] IDX_LAST  = BIT_IDX_W'(FRAME_DATA_BITS - 1);

  rx_state_t                  state_q;
  logic [BIT_CNT_W-1:0]       cnt_q;
  logic [BIT_IDX_W-1:0]       idx_q;
  logic [FRAME_DATA_BITS-1:0] shift_q;

  logic rxd_sync;
  logic fall;
  logic bit_tick;
  logic stop_smp;
  logic stop_good;
  logic room;

  serial_rx_sync u_sync (
    .clock    (clock),
    .reset_n  (reset_n),
    .rxd      (rxd),
    .rxd_sync (rxd_sync),
    .fall     (fall)
  );

  assign bit_tick  = (cnt_q == BIT_LAST);
  // Stop sample only counts while enabled; a disabled receiver aborts silently
  assign stop_smp  = rx_en && (state_q == R_STOP) && bit_tick;
  assign stop_good = stop_smp && (rxd_sync == STOP_LEVEL);
  // The register can take a byte if empty or being drained on this same edge
  assign room      = !rx_valid || rx_ready;

  // Status pulses live only in the stop-sample cycle and are mutually exclusive
  assign frame_error = stop_smp && (rxd_sync != STOP_LEVEL);
  assign overrun     = stop_good && !room;
  assign busy        = (state_q != R_IDLE);

  // Frame sequencer: hunt for start, verify it mid-bit, clock in data, sample stop
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= R_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else if (!rx_en) begin
      state_q <= R_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        R_IDLE: begin
          if (fall) begin
            state_q <= R_START;
            cnt_q   <= '0;
          end
        end
        R_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (rxd_sync == START_LEVEL) begin
              state_q <= R_DATA;
              idx_q   <= '0;
            end else begin
              // line already back high: treat as a glitch
              state_q <= R_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        R_DATA: begin
          if (bit_tick) begin
            shift_q <= {shift_q[FRAME_DATA_BITS-2:0], rxd_sync};
            cnt_q   <= '0;
            idx_q   <= idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              state_q <= R_STOP;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        R_STOP: begin
          if (bit_tick) begin
            cnt_q   <= '0;
            state_q <= R_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= R_IDLE;
          cnt_q   <= '0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  // Holding register: a load wins over a drain so back-to-back bytes keep rx_valid high
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (stop_good && room) begin
      rx_data  <= shift_q;
      rx_valid <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

endmodule
